// File: rtl/gamma_sequencer_if.sv
// Volley-in and result-out handshakes of the gamma sequencer.
// The slave modport is the sequencer side; the master modport is the encoder/consumer side.
interface gamma_sequencer_if #(
  parameter int unsigned NUM_SPIKES = 16,
  parameter int unsigned TBITS      = 4,
  parameter int unsigned NBITS      = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_SPIKES*TBITS-1:0] in_spike_times;
  logic                        out_valid;
  logic                        out_ready;
  logic [TBITS-1:0]            out_spike_time;
  logic [NBITS-1:0]            out_winner;

  modport master (
    output in_valid, in_spike_times, out_ready,
    input  in_ready, out_valid, out_spike_time, out_winner
  );

  modport slave (
    input  in_valid, in_spike_times, out_ready,
    output in_ready, out_valid, out_spike_time, out_winner
  );
endinterface

// File: rtl/gamma_sequencer.sv
// Gamma sequencer: latches one input volley, sweeps the layer's time_val
// through one gamma cycle, then captures winner and output spike time
// into a one-entry result buffer. time_val parks at TIME_PERIOD outside RUN.
module gamma_sequencer #(
  parameter int unsigned TIME_PERIOD = 8,
  parameter int unsigned NUM_SPIKES  = 16,
  parameter int unsigned NEURONS     = 8,
  parameter int unsigned TBITS       = $clog2(TIME_PERIOD) + 1,
  parameter int unsigned NBITS       = $clog2(NEURONS)
) (
  input  logic                        clk,
  input  logic                        rst,
  gamma_sequencer_if.slave            bus,
  output logic [TBITS-1:0]            time_val,
  output logic [NUM_SPIKES*TBITS-1:0] spike_times,
  input  logic [TBITS-1:0]            layer_spike_time,
  input  logic [NBITS-1:0]            layer_winner,
  output logic                        busy,
  output logic [15:0]                 volley_count,
  // test hook: synchronous preload of volley_count
  input  logic                        cnt_preload,
  input  logic [15:0]                 cnt_preload_val
);

  localparam logic [TBITS-1:0] PARK = TBITS'(TIME_PERIOD);
  localparam logic [TBITS-1:0] LAST = TBITS'(TIME_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                      state_q;
  logic [TBITS-1:0]            time_val_q;
  logic [NUM_SPIKES*TBITS-1:0] spike_times_q;
  logic [NBITS-1:0]            win_stage_q;
  logic [TBITS-1:0]            time_stage_q;
  logic                        first_cap_q;
  logic                        in_ready_q;
  logic                        busy_q;
  logic                        out_valid_q;
  logic [TBITS-1:0]            out_spike_time_q;
  logic [NBITS-1:0]            out_winner_q;
  logic [15:0]                 volley_count_q;
  logic [TBITS-1:0]            cap_time_d;

  // Layer result is only valid live on the first CAPTURE cycle; afterwards use the staged copy
  always_comb begin
    cap_time_d = time_stage_q;
    if (first_cap_q) cap_time_d = layer_spike_time;
  end

  // Sequencer FSM with registered outputs; time_val_q doubles as the tick counter in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      time_val_q       <= PARK;
      spike_times_q    <= '0;
      win_stage_q      <= '0;
      time_stage_q     <= '0;
      first_cap_q      <= 1'b0;
      in_ready_q       <= 1'b1;
      busy_q           <= 1'b0;
      out_valid_q      <= 1'b0;
      out_spike_time_q <= '0;
      out_winner_q     <= '0;
      volley_count_q   <= '0;
    end else begin
      // Consumption clears the buffer; a same-edge load below overrides this
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            spike_times_q <= bus.in_spike_times;
            time_val_q    <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_RUN;
          end
        end
        S_RUN: begin
          if (time_val_q == LAST) begin
            // Layer clears its winner on this edge, so grab it now
            win_stage_q <= layer_winner;
            time_val_q  <= PARK;
            first_cap_q <= 1'b1;
            state_q     <= S_CAPTURE;
          end else begin
            time_val_q <= time_val_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          first_cap_q <= 1'b0;
          if (first_cap_q) time_stage_q <= layer_spike_time;
          if (!out_valid_q || bus.out_ready) begin
            out_spike_time_q <= cap_time_d;
            out_winner_q     <= win_stage_q;
            out_valid_q      <= 1'b1;
            volley_count_q   <= volley_count_q + 16'd1;
            in_ready_q       <= 1'b1;
            busy_q           <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        default: begin
          time_val_q <= PARK;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase

      if (cnt_preload) volley_count_q <= cnt_preload_val;
    end
  end

  assign time_val           = time_val_q;
  assign spike_times        = spike_times_q;
  assign busy               = busy_q;
  assign volley_count       = volley_count_q;
  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_spike_time = out_spike_time_q;
  assign bus.out_winner     = out_winner_q;

endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed bench for gamma_sequencer (TIME_PERIOD=8, 16 synapses, 8 neurons).
// A tiny layer stand-in presents the winner only while time_val==7 and the
// spike time only on the first CAPTURE cycle, so stale sampling shows up.
module tb_gamma_sequencer;
  localparam logic [3:0] PARK = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gamma_sequencer_if #(.NUM_SPIKES(16), .TBITS(4), .NBITS(3)) bus_if ();

  logic [3:0]  time_val;
  logic [63:0] spike_times;
  logic [3:0]  layer_spike_time;
  logic [2:0]  layer_winner;
  logic        busy;
  logic [15:0] volley_count;
  logic        cnt_preload;
  logic [15:0] cnt_preload_val;

  logic [2:0]  win_val;
  logic [3:0]  st_val;
  logic [3:0]  prev_tv;

  int checks = 0;
  int errors = 0;

  gamma_sequencer #(
    .TIME_PERIOD(8),
    .NUM_SPIKES (16),
    .NEURONS    (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if),
    .time_val        (time_val),
    .spike_times     (spike_times),
    .layer_spike_time(layer_spike_time),
    .layer_winner    (layer_winner),
    .busy            (busy),
    .volley_count    (volley_count),
    .cnt_preload     (cnt_preload),
    .cnt_preload_val (cnt_preload_val)
  );

  // Layer stand-in
  always @(posedge clk) prev_tv <= time_val;
  assign layer_winner     = (time_val == 4'd7) ? win_val : ~win_val;
  assign layer_spike_time = (busy && time_val == PARK && prev_tv == 4'd7) ? st_val : 4'b0110;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle and out_ready=1; ends at the negedge
  // of the first cycle showing the result.
  task automatic do_volley(input logic [63:0] v, input logic [2:0] w,
                           input logic [3:0] st, input logic [15:0] cnt_exp);
    int n;
    win_val = w;
    st_val  = st;
    bus_if.in_spike_times = v;
    bus_if.in_valid       = 1'b1;
    n = 0;
    while (bus_if.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 40), 64'd1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(bus_if.in_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("tick", 64'(time_val), 64'(i));
      @(negedge clk);
    end
    check("cap_park", 64'(time_val), 64'(PARK));
    check("cap_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("held_volley", spike_times, v);
    @(negedge clk);
    check("res_valid", 64'(bus_if.out_valid), 64'd1);
    check("res_winner", 64'(bus_if.out_winner), 64'(w));
    check("res_time", 64'(bus_if.out_spike_time), 64'(st));
    check("res_count", 64'(volley_count), 64'(cnt_exp));
    check("res_idle_busy", 64'(busy), 64'd0);
    check("res_in_ready", 64'(bus_if.in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] va, vb;
    logic [3:0]  exp_tv;
    bus_if.in_valid       = 1'b0;
    bus_if.in_spike_times = '0;
    bus_if.out_ready      = 1'b1;
    cnt_preload           = 1'b0;
    cnt_preload_val       = '0;
    win_val               = '0;
    st_val                = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_time_val", 64'(time_val), 64'(PARK));
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("rst_count", 64'(volley_count), 64'd0);
    check("rst_spikes", spike_times, 64'd0);
    check("rst_out_time", 64'(bus_if.out_spike_time), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single volley
    do_volley(64'h0123_4567_89AB_CDEF, 3'd5, 4'd3, 16'd1);

    // Back-to-back volleys with in_valid held
    bus_if.in_spike_times = 64'hFEDC_BA98_7654_3210;
    bus_if.in_valid       = 1'b1;
    win_val = 3'd2;
    st_val  = 4'd5;
    for (int j = 0; j < 30; j++) begin
      if (j % 10 == 0 || j % 10 == 9) exp_tv = PARK;
      else exp_tv = 4'((j % 10) - 1);
      check("b2b_time_val", 64'(time_val), 64'(exp_tv));
      check("b2b_in_ready", 64'(bus_if.in_ready), 64'(j % 10 == 0));
      if (j > 0 && j % 10 == 0) begin
        check("b2b_out_valid", 64'(bus_if.out_valid), 64'd1);
        check("b2b_out_winner", 64'(bus_if.out_winner), 64'd2);
      end
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    check("b2b_count", 64'(volley_count), 64'd4);
    check("b2b_last_valid", 64'(bus_if.out_valid), 64'd1);
    check("b2b_last_time", 64'(bus_if.out_spike_time), 64'd5);
    @(negedge clk);

    // Stall: consumer not ready for 25 cycles, two volleys
    va = 64'h1111_2222_3333_4444;
    vb = 64'h5555_6666_7777_0000;
    bus_if.out_ready      = 1'b0;
    bus_if.in_spike_times = va;
    bus_if.in_valid       = 1'b1;
    win_val = 3'd6;
    st_val  = 4'd1;
    for (int s = 0; s < 25; s++) begin
      if (s == 1) bus_if.in_spike_times = vb;
      if (s == 10) begin
        win_val = 3'd4;
        st_val  = 4'd2;
      end
      if (s == 11) bus_if.in_valid = 1'b0;
      if (s == 5) check("stall_vol_a", spike_times, va);
      if (s == 12) check("stall_vol_b", spike_times, vb);
      if (s >= 10) begin
        check("stall_hold_valid", 64'(bus_if.out_valid), 64'd1);
        check("stall_hold_time", 64'(bus_if.out_spike_time), 64'd1);
        check("stall_hold_winner", 64'(bus_if.out_winner), 64'd6);
      end
      if (s >= 19) begin
        check("stall_park", 64'(time_val), 64'(PARK));
        check("stall_in_ready", 64'(bus_if.in_ready), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
      end
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("unstall_valid", 64'(bus_if.out_valid), 64'd1);
    check("unstall_time", 64'(bus_if.out_spike_time), 64'd2);
    check("unstall_winner", 64'(bus_if.out_winner), 64'd4);
    check("unstall_busy", 64'(busy), 64'd0);
    check("unstall_count", 64'(volley_count), 64'd6);

    // Reset mid-RUN with an unconsumed result pending
    bus_if.out_ready      = 1'b0;
    bus_if.in_spike_times = 64'hAAAA_5555_AAAA_5555;
    bus_if.in_valid       = 1'b1;
    win_val = 3'd7;
    st_val  = 4'd0;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_tick4", 64'(time_val), 64'd4);
    rst = 1'b1;
    #1;
    check("mid_rst_park", 64'(time_val), 64'(PARK));
    check("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(volley_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    do_volley(64'h0F0F_0F0F_1234_5678, 3'd1, 4'd7, 16'd1);

    // No-spike result passes through
    do_volley(64'h0000_0000_0000_0001, 3'd3, 4'b1000, 16'd2);

    // volley_count wrap via preload hook
    cnt_preload     = 1'b1;
    cnt_preload_val = 16'hFFFF;
    @(negedge clk);
    cnt_preload = 1'b0;
    check("preload_count", 64'(volley_count), 64'hFFFF);
    do_volley(64'h8765_4321_0000_FFFF, 3'd0, 4'd2, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gamma_sequencer.md
Name: gamma_sequencer

Overview:
Controller that drives one SNN layer through its gamma cycles. It accepts an input spike volley over a valid/ready handshake and holds it stable on the layer's spike_times bus. It sweeps time_val 0..TIME_PERIOD-1 once per volley, then captures the layer's winner and output spike time into a one-entry result buffer with a valid/ready output. It sits between the input encoder / volley FIFO and the layer instance, and is the only driver of the layer's time_val.

Parameters:
TIME_PERIOD, 8, gamma-cycle length in ticks; power of two, at least 4
NUM_SPIKES, 16, input synapses per volley
NEURONS, 8, neurons in the driven layer
TBITS, $clog2(TIME_PERIOD)+1, spike-time width; MSB set means "no spike"
NBITS, $clog2(NEURONS), winner index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input volley present
in_ready  out  1  sequencer can take a volley
in_spike_times  in  NUM_SPIKES*TBITS  volley; entry i occupies bits [i*TBITS +: TBITS]
time_val  out  TBITS  tick value to the layer
spike_times  out  NUM_SPIKES*TBITS  held volley to the layer
layer_spike_time  in  TBITS  layer output_spike_time
layer_winner  in  NBITS  layer winning_neuron
out_valid  out  1  result buffer full
out_ready  in  1  consumer takes result
out_spike_time  out  TBITS  captured output spike time
out_winner  out  NBITS  captured winner index
busy  out  1  state is not IDLE
volley_count  out  16  number of completed gammas; wraps at 2^16

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, time_val=PARK, spike_times=0, out_valid=0, out_spike_time=0, out_winner=0, volley_count=0, busy=0.
- PARK is the constant TIME_PERIOD. It never equals TIME_PERIOD-1, so the layer does no learning or output update while parked. time_val=PARK in every state except RUN.
- State IDLE: in_ready=1. An in_valid&in_ready edge loads in_spike_times into the volley register; the next state is RUN with tick=0.
- State RUN: time_val=tick, and tick increments by 1 per cycle.
  - On the edge ending the tick==TIME_PERIOD-1 cycle, sample layer_winner into win_stage. The layer clears its winner on that edge.
  - Go to CAPTURE.
- State CAPTURE (at least 1 cycle): layer_spike_time now holds the gamma result.
  - On the first CAPTURE cycle, sample layer_spike_time into time_stage.
  - If out_valid==0, or out_valid&out_ready in this cycle: load out_spike_time<=time_stage (or the live layer_spike_time on the first cycle), out_winner<=win_stage, out_valid<=1, volley_count+=1, then go to IDLE.
  - Otherwise stay in CAPTURE (stall) with the staged values held.
- Latency: accept on edge k; time_val=0 during cycle k+1; time_val=TIME_PERIOD-1 during cycle k+TIME_PERIOD; out_valid=1 from cycle k+TIME_PERIOD+2 when unstalled.
- Throughput: one volley per TIME_PERIOD+2 cycles. A new volley can be accepted in the cycle after CAPTURE exits, while the previous result is still unconsumed.
- Output buffer:
  - out_valid clears on an out_valid&out_ready edge, unless the same edge loads a new result, in which case it stays 1.
  - Outputs are stable while out_valid&!out_ready.
- spike_times holds the last loaded volley until the next accept, including through IDLE.
- in_ready=0 in RUN and CAPTURE. in_valid is ignored there, and no data is lost because the source holds in_valid.
- Reset mid-RUN aborts the gamma: time_val goes to PARK at once, no result is produced, and volley_count is not incremented.
- No-spike results (MSB of layer_spike_time set) pass through unchanged; the winner is still reported.
- volley_count wraps from 16'hFFFF to 0.

Test Plan:
- Single volley, TIME_PERIOD=8, out_ready=1; accept at edge 0 -> time_val 0..7 in cycles 1..8, PARK in cycle 9; out_valid=1 in cycle 10 with out_winner equal to layer_winner sampled in cycle 8 and out_spike_time equal to layer_spike_time in cycle 9; volley_count=1.
- Back-to-back volleys, in_valid held, out_ready=1 -> accepts at cycles 0, 10, 20; time_val never shows TIME_PERIOD-1 outside RUN; volley_count=3 after three results.
- out_ready=0 for 25 cycles with two volleys -> first result held stable; second gamma stalls in CAPTURE with time_val=PARK and in_ready=0; on out_ready=1 the second result loads on the same edge and out_valid stays 1.
- Reset asserted at tick 4 of RUN -> time_val=PARK, out_valid=0, busy=0 immediately; volley_count unchanged at 0; the next volley runs a clean 0..7 sweep.
- Layer returns layer_spike_time=4'b1000 (no spike) with winner 3 -> out_spike_time=4'b1000, out_winner=3.
- Preload volley_count to 16'hFFFF via the test hook, complete one gamma -> volley_count=0.
